// File: rtl/tetris_input_pkg.sv
// Shared defaults, repeat-FSM encoding and gravity period helper for the
// falling-block input conditioner.
package tetris_input_pkg;

    localparam int unsigned DB_CYCLES_DEF  = 500000;
    localparam int unsigned DAS_CYCLES_DEF = 10000000;
    localparam int unsigned ARR_CYCLES_DEF = 2500000;
    localparam int unsigned GRAV_BASE_DEF  = 50000000;
    localparam int unsigned GRAV_STEP_DEF  = 4000000;
    localparam int unsigned GRAV_MIN_DEF   = 5000000;

    // state  | meaning
    // IDLE   | key released, waiting for a debounced press
    // DELAY  | held, counting down the initial auto-repeat delay
    // REPEAT | held, firing once per auto-repeat period
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic logic [31:0] grav_period(input logic [3:0]  lvl,
                                                input logic [31:0] base,
                                                input logic [31:0] step,
                                                input logic [31:0] min_period);
        logic [31:0] dec;
        dec = 32'(lvl) * step;
        if ((base > dec) && ((base - dec) > min_period))
            return base - dec;
        return min_period;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One key channel: 2-flop synchronizer followed by a stability-window
// debouncer. Output is active-low like the raw key (1 = released).
module debounce_ch
    import tetris_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic key_db_n
);

    localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            key_db_n <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            // a single agreeing sample restarts the stability window
            if (sync2 == key_db_n) begin
                cnt <= '0;
            end else if (cnt >= DB_LAST) begin
                key_db_n <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces three push-buttons, generates left/right auto-repeat move pulses,
// a single rotate pulse per press, and a level-dependent gravity tick.
module input_conditioner
    import tetris_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned DAS_CYCLES = DAS_CYCLES_DEF,
    parameter int unsigned ARR_CYCLES = ARR_CYCLES_DEF,
    parameter int unsigned GRAV_BASE  = GRAV_BASE_DEF,
    parameter int unsigned GRAV_STEP  = GRAV_STEP_DEF,
    parameter int unsigned GRAV_MIN   = GRAV_MIN_DEF
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       KEY_left_n,
    input  logic       KEY_right_n,
    input  logic       KEY_rot_n,
    input  logic       gravity_en,
    input  logic [3:0] level,
    output logic       left_final,
    output logic       right_final,
    output logic       rot_final,
    output logic       tick_gravity
);

    localparam logic [31:0] DAS_LAST = 32'(DAS_CYCLES - 1);
    localparam logic [31:0] ARR_LAST = 32'(ARR_CYCLES - 1);

    logic left_db_n;
    logic right_db_n;
    logic rot_db_n;
    logic rot_db_prev_n;

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .key_n    (KEY_left_n),
        .key_db_n (left_db_n)
    );

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .key_n    (KEY_right_n),
        .key_db_n (right_db_n)
    );

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_rot (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .key_n    (KEY_rot_n),
        .key_db_n (rot_db_n)
    );

    // index 0 = left, 1 = right
    logic [1:0]       pressed;
    logic             both_held;
    logic [1:0][1:0]  rep_state;
    logic [1:0][1:0]  rep_state_nx;
    logic [1:0][31:0] rep_cnt;
    logic [1:0][31:0] rep_cnt_nx;
    logic [1:0]       rep_req;

    assign pressed   = {~right_db_n, ~left_db_n};
    assign both_held = &pressed;

    always_comb begin
        rep_state_nx = rep_state;
        rep_cnt_nx   = rep_cnt;
        rep_req      = '0;
        for (int i = 0; i < 2; i++) begin
            if (!pressed[i]) begin
                rep_state_nx[i] = ST_IDLE;
                rep_cnt_nx[i]   = '0;
            end else begin
                case (rep_state[i])
                    ST_IDLE: begin
                        rep_state_nx[i] = ST_DELAY;
                        rep_cnt_nx[i]   = DAS_LAST;
                        rep_req[i]      = 1'b1;
                    end
                    ST_DELAY: begin
                        if (rep_cnt[i] == '0) begin
                            rep_state_nx[i] = ST_REPEAT;
                            rep_cnt_nx[i]   = ARR_LAST;
                            rep_req[i]      = 1'b1;
                        end else begin
                            rep_cnt_nx[i] = rep_cnt[i] - 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rep_cnt[i] == '0) begin
                            rep_cnt_nx[i] = ARR_LAST;
                            rep_req[i]    = 1'b1;
                        end else begin
                            rep_cnt_nx[i] = rep_cnt[i] - 32'd1;
                        end
                    end
                    default: begin
                        rep_state_nx[i] = ST_IDLE;
                        rep_cnt_nx[i]   = '0;
                    end
                endcase
            end
        end
    end

    // FSMs keep advancing while both keys are held; only the outputs are masked
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            rep_state     <= {ST_IDLE, ST_IDLE};
            rep_cnt       <= '0;
            left_final    <= 1'b0;
            right_final   <= 1'b0;
            rot_final     <= 1'b0;
            rot_db_prev_n <= 1'b1;
        end else begin
            rep_state     <= rep_state_nx;
            rep_cnt       <= rep_cnt_nx;
            left_final    <= rep_req[0] & ~both_held;
            right_final   <= rep_req[1] & ~both_held;
            rot_final     <= rot_db_prev_n & ~rot_db_n;
            rot_db_prev_n <= rot_db_n;
        end
    end

    logic [31:0] grav_per;
    logic [31:0] grav_last;
    logic [31:0] grav_cnt;

    assign grav_per  = grav_period(level, GRAV_BASE, GRAV_STEP, GRAV_MIN);
    assign grav_last = (grav_per == '0) ? '0 : grav_per - 32'd1;

    // >= rather than == so a level increase past the current count fires at once
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            grav_cnt     <= '0;
            tick_gravity <= 1'b0;
        end else if (!gravity_en) begin
            grav_cnt     <= '0;
            tick_gravity <= 1'b0;
        end else if (grav_cnt >= grav_last) begin
            grav_cnt     <= '0;
            tick_gravity <= 1'b1;
        end else begin
            grav_cnt     <= grav_cnt + 32'd1;
            tick_gravity <= 1'b0;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner against a timestamp-based
// behavioural model with small debounce/repeat/gravity parameters.
module tb_input_conditioner;

    localparam int DB   = 4;
    localparam int DAS  = 10;
    localparam int ARR  = 3;
    localparam int GB   = 20;
    localparam int GS   = 2;
    localparam int GMIN = 6;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] keys_n = 3'b111;
    logic       gravity_en = 1'b0;
    logic [3:0] level = 4'd0;
    logic       left_final, right_final, rot_final, tick_gravity;

    input_conditioner #(
        .DB_CYCLES(DB), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR),
        .GRAV_BASE(GB), .GRAV_STEP(GS), .GRAV_MIN(GMIN)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .KEY_left_n   (keys_n[0]),
        .KEY_right_n  (keys_n[1]),
        .KEY_rot_n    (keys_n[2]),
        .gravity_en   (gravity_en),
        .level        (level),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int lq[$], rq[$], oq[$], tq[$];

    // model state: sync pipeline, debounced level, disagreement run, press timestamp
    bit ms1[3] = '{1'b1, 1'b1, 1'b1};
    bit ms2[3] = '{1'b1, 1'b1, 1'b1};
    bit mdb[3] = '{1'b1, 1'b1, 1'b1};
    int mrun[3] = '{0, 0, 0};
    int mpress[3] = '{0, 0, 0};
    int g_el = 0;
    bit e_left = 0, e_right = 0, e_rot = 0, e_tick = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit pre_db[3];
        bit fire[3];
        int d;
        int per;
        if (!resetn) begin
            for (int k = 0; k < 3; k++) begin
                ms1[k] = 1; ms2[k] = 1; mdb[k] = 1; mrun[k] = 0;
            end
            g_el = 0;
            e_left = 0; e_right = 0; e_rot = 0; e_tick = 0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            pre_db[k] = mdb[k];
            fire[k] = 0;
            if (!pre_db[k]) begin
                d = cyc - mpress[k] - 1;
                if (k == 2) fire[k] = (d == 0);
                else        fire[k] = (d == 0) || (d >= DAS && ((d - DAS) % ARR) == 0);
            end
        end
        e_left  = fire[0] && !(!pre_db[0] && !pre_db[1]);
        e_right = fire[1] && !(!pre_db[0] && !pre_db[1]);
        e_rot   = fire[2];
        per = GB - int'(level) * GS;
        if (per < GMIN) per = GMIN;
        if (!gravity_en) begin
            g_el = 0; e_tick = 0;
        end else if (g_el >= per - 1) begin
            g_el = 0; e_tick = 1;
        end else begin
            g_el++; e_tick = 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (ms2[k] != mdb[k]) begin
                mrun[k]++;
                if (mrun[k] == DB) begin
                    mdb[k] = ms2[k];
                    mrun[k] = 0;
                    if (!mdb[k]) mpress[k] = cyc;
                end
            end else begin
                mrun[k] = 0;
            end
            ms2[k] = ms1[k];
            ms1[k] = keys_n[k];
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        cyc++;
        model_edge();
        @(negedge CLOCK_50);
        chk("outs", {28'd0, left_final, right_final, rot_final, tick_gravity},
                    {28'd0, e_left, e_right, e_rot, e_tick});
        if (left_final)   lq.push_back(cyc);
        if (right_final)  rq.push_back(cyc);
        if (rot_final)    oq.push_back(cyc);
        if (tick_gravity) tq.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_q();
        lq.delete(); rq.delete(); oq.delete(); tq.delete();
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000000;
    endfunction

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_after(input int q[$], input int t);
        foreach (q[i]) if (q[i] > t) return q[i];
        return -1000000;
    endfunction

    initial begin
        int t0, t1, d;
        int bounce_exp[6] = '{7, 17, 20, 23, 26, 29};
        int lvls[3] = '{0, 5, 15};
        int pers[3] = '{20, 10, 6};
        int hold[3] = '{0, 0, 0};

        run(3);
        chk("reset_outs", {28'd0, left_final, right_final, rot_final, tick_gravity}, 32'd0);
        resetn = 1'b1;
        run(5);

        // rotate: one pulse only, DB+3 after the edge
        clear_q();
        keys_n[2] = 1'b0; t0 = cyc;
        run(50);
        keys_n[2] = 1'b1;
        run(12);
        chk("rot_count", oq.size(), 1);
        chk("rot_latency", q_at(oq, 0) - t0, 7);

        // left bounce then stable hold
        clear_q();
        repeat (5) begin
            keys_n[0] = 1'b0; run(3);
            keys_n[0] = 1'b1; run(1);
        end
        keys_n[0] = 1'b0; t0 = cyc;
        run(30);
        keys_n[0] = 1'b1;
        run(12);
        chk("bounce_count", count_in(lq, 0, t0 + 30), 6);
        for (int i = 0; i < 6; i++) chk("bounce_pulse", q_at(lq, i) - t0, bounce_exp[i]);

        // left held, right pressed and released
        clear_q();
        keys_n[0] = 1'b0; t0 = cyc;
        run(20);
        keys_n[1] = 1'b0; t1 = cyc;
        run(15);
        keys_n[1] = 1'b1;
        run(20);
        keys_n[0] = 1'b1;
        run(12);
        chk("left_before_both", count_in(lq, t0 + 1, t1 + 6), 5);
        chk("left_while_both", count_in(lq, t1 + 7, t0 + 41), 0);
        chk("right_while_both", rq.size(), 0);
        chk("left_resume", first_after(lq, t0 + 41) - t0, 44);

        // gravity period per level, each phase started from a cleared counter
        for (int i = 0; i < 3; i++) begin
            gravity_en = 1'b0; level = 4'(lvls[i]);
            run(1);
            clear_q();
            gravity_en = 1'b1; t0 = cyc;
            run(3 * pers[i] + 2);
            chk("grav_first", q_at(tq, 0) - t0, pers[i]);
            chk("grav_period_a", q_at(tq, 1) - q_at(tq, 0), pers[i]);
            chk("grav_period_b", q_at(tq, 2) - q_at(tq, 1), pers[i]);
        end

        // level change mid-count, then a one-cycle disable
        gravity_en = 1'b0; level = 4'd0;
        run(1);
        clear_q();
        gravity_en = 1'b1; t0 = cyc;
        run(15);
        level = 4'd5;
        run(1);
        chk("level_switch_tick", q_at(tq, 0) - t0, 16);
        gravity_en = 1'b0; level = 4'd0;
        run(1);
        d = cyc;
        clear_q();
        gravity_en = 1'b1;
        run(22);
        chk("reenable_tick", q_at(tq, 0) - d, 20);
        gravity_en = 1'b0;
        run(2);

        // reset lands on the cycle a REPEAT pulse was due
        clear_q();
        keys_n[0] = 1'b0;
        run(25);
        resetn = 1'b0;
        run(1);
        chk("reset_mid_repeat", {28'd0, left_final, right_final, rot_final, tick_gravity}, 32'd0);
        resetn = 1'b1; t0 = cyc;
        clear_q();
        run(20);
        chk("post_reset_first", q_at(lq, 0) - t0, 7);
        chk("post_reset_second", q_at(lq, 1) - t0, 17);
        keys_n[0] = 1'b1;
        run(12);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    keys_n[k] = ~keys_n[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 8));
                end else begin
                    hold[k]--;
                end
            end
            if ($urandom_range(0, 49) == 0) gravity_en = ~gravity_en;
            if ($urandom_range(0, 39) == 0) level = 4'($urandom_range(0, 15));
            resetn = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
